reaction_timer: RTL and testbench
=================================

// Module: reaction_timer
// PURPOSE
//   Consumer of the 9-bit pseudo-random value from pngenerator. On start, latches
//   the random value as a delay in ms, waits that long, lights the GO indicator,
//   then measures the ms until the player reacts. Sits between the button
//   debouncers / pngenerator and the 7-segment display driver.
// PARAMETERS
//   TICK_DIV      100000  clk cycles per 1 ms tick (100 MHz board clock)
//   MIN_DELAY_MS  1000    fixed ms added to random value (delay = MIN_DELAY_MS + rnd)
//   MAX_MS        9999    reaction-time saturation value (4-digit display limit)
// PORTS
//   clk       in   1   system clock
//   rst       in   1   synchronous, active-high reset
//   start     in   1   single-cycle pulse (debounced): arm a new round
//   react     in   1   single-cycle pulse (debounced): player response
//   rnd       in   9   current pngenerator output, sampled only on accepted start
//   go_led    out  1   high while in GO
//   busy      out  1   high in WAIT or GO
//   done      out  1   high in DONE (valid result on time_ms)
//   early     out  1   high in EARLY (false start)
//   time_ms   out  14  reaction time in ms; held after DONE/EARLY until next start
// BEHAVIOUR
//   Clock is clk; reset rst is synchronous, active-high; all state updates on posedge clk.
//   Reset: state=IDLE; go_led=busy=done=early=0; time_ms=0; tick and delay counters 0.
//   States: IDLE, WAIT, GO, DONE, EARLY. Outputs are registered decodes of state.
//   Tick: tick_cnt counts 0..TICK_DIV-1, tick pulse when tick_cnt==TICK_DIV-1;
//     tick_cnt cleared on every state transition, so first tick comes TICK_DIV
//     cycles after state entry.
//   IDLE/DONE/EARLY + start -> WAIT next cycle; delay_cnt <= MIN_DELAY_MS + rnd
//     (11-bit add, no overflow for defaults); time_ms <= 0.
//   WAIT: each tick delay_cnt -= 1; tick with delay_cnt==1 -> GO. So GO entered
//     exactly (MIN_DELAY_MS+rnd)*TICK_DIV cycles after WAIT entry.
//   WAIT + react -> EARLY (react wins over a same-cycle tick); time_ms stays 0.
//   GO: each tick time_ms += 1; react -> DONE with time_ms frozen; if react and
//     tick coincide, react wins and the increment is NOT applied.
//   GO: tick with time_ms==MAX_MS-1 -> time_ms=MAX_MS and -> DONE (timeout).
//   start while WAIT or GO: ignored. react in IDLE/DONE/EARLY: ignored.
//   start and react same cycle in IDLE/DONE/EARLY: start wins -> WAIT.
//   rst mid-round (any state): back to reset values next cycle, no residue.
//   rnd sampled only on accepted start; changes on rnd at other times have no effect.
//   Latency: outputs reflect new state one cycle after the causing input edge.
// TESTING (sim params TICK_DIV=4, MIN_DELAY_MS=2, MAX_MS=20)
//   Reset: rst high 2 cycles -> all outputs 0, state IDLE; react pulses ignored.
//   Normal round: start with rnd=3 -> busy=1; go_led rises 20 cycles after WAIT
//     entry; react after 3 ticks (~13 cycles) -> done=1, go_led=0, time_ms=3.
//   False start: start rnd=5, react 10 cycles later -> early=1, busy=0, time_ms=0;
//     new start -> WAIT, early=0.
//   Timeout: start rnd=0, no react -> done=1, time_ms=20 after 80 cycles of GO.
//   Collisions: react on same cycle as GO tick -> time_ms not incremented;
//     start during WAIT/GO ignored; start+react in DONE -> WAIT.
//   Reset mid-GO with time_ms=7 -> next cycle time_ms=0, go_led=0, IDLE.

Source files
------------

// File: rtl/reaction_timer.sv
// Reaction timer: random-delay GO indicator, then ms count until react.
// Saturates at MAX_MS; result held until the next accepted start.
module reaction_timer #(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        react,
  input  logic [8:0]  rnd,
  output logic        go_led,
  output logic        busy,
  output logic        done,
  output logic        early,
  output logic [13:0] time_ms
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [10:0]   MIN_D     = 11'(MIN_DELAY_MS);
  localparam logic [13:0]   TIME_LAST = 14'(MAX_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_EARLY
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [10:0]   delay_cnt, delay_n;
  logic [13:0]   time_n;

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    state_n = state;
    delay_n = delay_cnt;
    time_n  = time_ms;
    unique case (state)
      S_IDLE, S_DONE, S_EARLY: begin
        if (start) begin
          state_n = S_WAIT;
          delay_n = MIN_D + 11'(rnd);
          time_n  = '0;
        end
      end
      S_WAIT: begin
        // react beats a same-cycle tick
        if (react) begin
          state_n = S_EARLY;
        end else if (tick) begin
          delay_n = delay_cnt - 11'd1;
          if (delay_cnt <= 11'd1)
            state_n = S_GO;
        end
      end
      S_GO: begin
        if (react) begin
          state_n = S_DONE;
        end else if (tick) begin
          time_n = time_ms + 14'd1;
          if (time_ms == TIME_LAST)
            state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      delay_cnt <= '0;
      time_ms   <= '0;
      go_led    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      early     <= 1'b0;
    end else begin
      state     <= state_n;
      delay_cnt <= delay_n;
      time_ms   <= time_n;
      // restart the ms grid on every state change
      if (state_n != state || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TW'(1);
      go_led <= (state_n == S_GO);
      busy   <= (state_n == S_WAIT) || (state_n == S_GO);
      done   <= (state_n == S_DONE);
      early  <= (state_n == S_EARLY);
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: timestamp-based model checked every cycle,
// plus directed rounds with hand-computed expectations.
module tb_reaction_timer;

  localparam int TD   = 4;
  localparam int MIN  = 2;
  localparam int MAXT = 20;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_GO    = 2;
  localparam int M_DONE  = 3;
  localparam int M_EARLY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic [8:0]  rnd = '0;
  logic        go_led, busy, done, early;
  logic [13:0] time_ms;

  int n_cmp = 0;
  int n_bad = 0;

  reaction_timer #(
    .TICK_DIV(TD),
    .MIN_DELAY_MS(MIN),
    .MAX_MS(MAXT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .react(react),
    .rnd(rnd),
    .go_led(go_led),
    .busy(busy),
    .done(done),
    .early(early),
    .time_ms(time_ms)
  );

  always #5 clk = ~clk;

  // model: edge index e; a round is described by its start and GO edges
  int e = 0;
  int t0 = 0;
  int dly = 0;
  int g0 = 0;
  int mode = M_IDLE;
  int mtime = 0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    e <= e + 1;
    if (rst) begin
      mode  <= M_IDLE;
      mtime <= 0;
      armed <= 1'b1;
    end else begin
      case (mode)
        M_WAIT: begin
          if (react) begin
            mode <= M_EARLY;
          end else if (e - t0 == dly) begin
            mode <= M_GO;
            g0   <= e;
          end
        end
        M_GO: begin
          if (react) begin
            mode  <= M_DONE;
            mtime <= (e - g0 - 1) / TD;
          end else if (e - g0 == MAXT * TD) begin
            mode  <= M_DONE;
            mtime <= MAXT;
          end else begin
            mtime <= (e - g0) / TD;
          end
        end
        default: begin
          if (start) begin
            mode  <= M_WAIT;
            t0    <= e;
            dly   <= (MIN + int'(rnd)) * TD;
            mtime <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      n_cmp++;
      if (go_led !== (mode == M_GO) ||
          busy !== (mode == M_WAIT || mode == M_GO) ||
          done !== (mode == M_DONE) ||
          early !== (mode == M_EARLY) ||
          time_ms !== 14'(mtime)) begin
        n_bad++;
        $display("FAIL model t=%0t: go/busy/done/early/time got %b%b%b%b/%0d want %b%b%b%b/%0d",
                 $time, go_led, busy, done, early, time_ms,
                 mode == M_GO, mode == M_WAIT || mode == M_GO,
                 mode == M_DONE, mode == M_EARLY, mtime);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [8:0] r);
    rnd   = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rnd   = 9'($urandom);
  endtask

  task automatic pulse_react();
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
  endtask

  task automatic wait_go(input int budget, output int k);
    k = 0;
    while (go_led !== 1'b1 && k < budget) begin
      @(negedge clk);
      rnd = 9'($urandom);
      k++;
    end
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_react();
    @(negedge clk);
    chk("rst_go", go_led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_early", early, 0);
    chk("rst_time", time_ms, 0);

    // normal round, rnd=3 -> 5 ms delay
    pulse_start(9'd3);
    chk("norm_busy", busy, 1);
    wait_go(40, k);
    chk("norm_go_delay", k, 20);
    repeat (13) @(negedge clk);
    pulse_react();
    chk("norm_done", done, 1);
    chk("norm_go_off", go_led, 0);
    chk("norm_time", time_ms, 3);

    // starts during WAIT/GO ignored; react lands on 2nd GO tick
    pulse_start(9'd0);
    repeat (2) @(negedge clk);
    pulse_start(9'd100);
    wait_go(40, k);
    chk("ign_go_delay", k, 5);
    pulse_start(9'd50);
    chk("ign_go_held", go_led, 1);
    repeat (6) @(negedge clk);
    pulse_react();
    chk("coll_done", done, 1);
    chk("coll_time", time_ms, 1);

    // start+react in DONE -> WAIT
    rnd   = 9'd5;
    start = 1'b1;
    react = 1'b1;
    @(negedge clk);
    start = 1'b0;
    react = 1'b0;
    chk("sr_busy", busy, 1);
    chk("sr_done", done, 0);
    chk("sr_time", time_ms, 0);

    // false start
    repeat (9) @(negedge clk);
    pulse_react();
    chk("fs_early", early, 1);
    chk("fs_busy", busy, 0);
    chk("fs_time", time_ms, 0);
    pulse_start(9'd0);
    chk("fs_restart_busy", busy, 1);
    chk("fs_restart_early", early, 0);

    // timeout
    wait_go(40, k);
    chk("to_go_delay", k, 8);
    wait_done(200, k);
    chk("to_go_len", k, 80);
    chk("to_time", time_ms, 20);
    chk("to_go_off", go_led, 0);
    pulse_react();
    chk("to_react_ign_done", done, 1);
    chk("to_react_ign_time", time_ms, 20);

    // reset mid-GO
    pulse_start(9'd0);
    wait_go(40, k);
    chk("rg_go_delay", k, 8);
    repeat (28) @(negedge clk);
    chk("rg_time_pre", time_ms, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rg_time", time_ms, 0);
    chk("rg_go", go_led, 0);
    chk("rg_busy", busy, 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
